div_scheduler: RTL and testbench

//  Shares one multi-cycle iterative divider (DIV/DIVU/REM/REMU) between NUM_REQ requesters.

---
 rtl/div_sched_pkg.sv | 15 +
 rtl/div_scheduler_rr_arbiter.sv | 30 +++
 rtl/div_scheduler.sv | 103 ++++++++++
 tb/tb_div_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_sched_pkg.sv
// rtl/div_sched_pkg.sv - shared types, ALU divide function codes and helpers for the divider scheduler
package div_sched_pkg;

  localparam logic [4:0] ALU_DIV  = 5'h0c;
  localparam logic [4:0] ALU_DIVU = 5'h0d;
  localparam logic [4:0] ALU_REM  = 5'h0e;
  localparam logic [4:0] ALU_REMU = 5'h0f;

  typedef enum logic [1:0] {DS_IDLE, DS_RUN, DS_RESP} ds_state_e;

  function automatic logic is_rem(input logic [4:0] func);
    return (func == ALU_REM) || (func == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_scheduler_rr_arbiter.sv
// rtl/div_scheduler_rr_arbiter.sv - combinational round-robin arbiter, first request at/after pointer wins
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/div_scheduler.sv
// rtl/div_scheduler.sv - shares one iterative divider between NUM_REQ requesters with round-robin grant
module div_scheduler
  import div_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][31:0]      req_opa,
  input  logic [NUM_REQ-1:0][31:0]      req_opb,
  input  logic [NUM_REQ-1:0][4:0]       req_func,
  input  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            flush,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [31:0]                   resp_data,
  output logic [TAG_W-1:0]              resp_tag,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [31:0]                   div_opa,
  output logic [31:0]                   div_opb,
  output logic [4:0]                    div_func,
  input  logic [31:0]                   div_quotient,
  input  logic [31:0]                   div_remainder,
  input  logic                          div_busy,
  output logic [31:0]                   busy_cycles
);

  localparam int PW = $clog2(NUM_REQ);

  ds_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q, owner_q, grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic          grant_any;

  // A requester being flushed this cycle is invisible to arbitration.
  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req       (req_valid & ~flush),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DS_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (grant_any) state_d = DS_RUN;
      DS_RUN: begin
        if (flush[owner_q])  state_d = DS_IDLE;
        else if (!div_busy)  state_d = DS_RESP;
      end
      DS_RESP: if (flush[owner_q] || resp_ready[owner_q]) state_d = DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == DS_IDLE) ? grant : '0;
    resp_valid = '0;
    if (state_q == DS_RESP) resp_valid[owner_q] = 1'b1;
  end

  // div_* keep the last issued operands when idle so the divider stays quiescent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      div_opa     <= '0;
      div_opb     <= '0;
      div_func    <= ALU_DIVU;
      resp_data   <= '0;
      resp_tag    <= '0;
      busy_cycles <= '0;
    end else begin
      case (state_q)
        DS_IDLE: begin
          if (grant_any) begin
            div_opa  <= req_opa[grant_idx];
            div_opb  <= req_opb[grant_idx];
            div_func <= req_func[grant_idx];
            resp_tag <= req_tag[grant_idx];
            owner_q  <= grant_idx;
            ptr_q    <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
          end
        end
        DS_RUN: begin
          busy_cycles <= busy_cycles + 32'd1;
          if (!flush[owner_q] && !div_busy)
            resp_data <= is_rem(div_func) ? div_remainder : div_quotient;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_scheduler.sv
// tb/tb_div_scheduler.sv - directed self-checking bench for div_scheduler with a behavioural iterative divider
module tb_div_scheduler;
  import div_sched_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int TAG_W   = 5;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][31:0]      req_opa;
  logic [NUM_REQ-1:0][31:0]      req_opb;
  logic [NUM_REQ-1:0][4:0]       req_func;
  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            flush;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [31:0]                   resp_data;
  logic [TAG_W-1:0]              resp_tag;
  logic [NUM_REQ-1:0]            resp_ready;
  logic [31:0]                   div_opa, div_opb, div_quotient, div_remainder, busy_cycles;
  logic [4:0]                    div_func;
  logic                          div_busy;

  int tests = 0;
  int fails = 0;

  div_scheduler #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_opa(req_opa), .req_opb(req_opb),
    .req_func(req_func), .req_tag(req_tag), .req_ready(req_ready),
    .flush(flush),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag),
    .resp_ready(resp_ready),
    .div_opa(div_opa), .div_opb(div_opb), .div_func(div_func),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_busy(div_busy), .busy_cycles(busy_cycles)
  );

  always #5 clk = ~clk;

  // Divider model: busy for 16 cycles after an operand change, immediately done on edge cases.
  logic [31:0] m_a, m_b;
  logic [4:0]  m_f;
  int          m_cnt;
  logic        m_diff, m_edge, m_sgn;

  always_comb begin
    m_sgn  = (div_func == ALU_DIV) || (div_func == ALU_REM);
    m_diff = ({div_opa, div_opb, div_func} != {m_a, m_b, m_f});
    m_edge = (div_opb == 32'd0) ||
             (m_sgn && div_opa == 32'h8000_0000 && div_opb == 32'hFFFF_FFFF);
    div_busy = m_diff ? !m_edge : (m_cnt != 0);
    if (div_opb == 32'd0) begin
      div_quotient  = 32'hFFFF_FFFF;
      div_remainder = div_opa;
    end else if (m_edge) begin
      div_quotient  = div_opa;
      div_remainder = 32'd0;
    end else if (m_sgn) begin
      div_quotient  = $signed(div_opa) / $signed(div_opb);
      div_remainder = $signed(div_opa) % $signed(div_opb);
    end else begin
      div_quotient  = div_opa / div_opb;
      div_remainder = div_opa % div_opb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a <= '0; m_b <= '0; m_f <= ALU_DIVU; m_cnt <= 0;
    end else if (m_diff) begin
      m_a <= div_opa; m_b <= div_opb; m_f <= div_func;
      m_cnt <= m_edge ? 0 : 15;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
  endtask

  task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] f, input logic [TAG_W-1:0] t,
                        input logic [31:0] exp_d, input int exp_lat,
                        input logic [1:0] exp_grant, input bit ack);
    int lat;
    logic [1:0] exp_v;
    exp_v = '0;
    exp_v[r] = 1'b1;
    @(negedge clk);
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_opa[r] = a; req_opb[r] = b; req_func[r] = f; req_tag[r] = t;
    #1;
    chk("grant", 32'(req_ready), 32'(exp_grant));
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) req_valid[r] = 1'b0;
      #1;
      if (resp_valid != '0) begin
        lat = n;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("resp_valid", 32'(resp_valid), 32'(exp_v));
    chk("resp_data", resp_data, exp_d);
    chk("resp_tag", 32'(resp_tag), 32'(t));
    if (ack) begin
      resp_ready[r] = 1'b1;
      @(negedge clk);
      resp_ready[r] = 1'b0;
      #1;
      chk("resp_done", 32'(resp_valid), 32'd0);
    end
  endtask

  logic [1:0] gseq [4];
  int gcount, rc0, rc1, seen;

  initial begin
    rst = 1'b1;
    req_valid = '0; req_opa = '0; req_opb = '0; req_func = '0; req_tag = '0;
    flush = '0; resp_ready = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_div_opa", div_opa, 32'd0);
    chk("rst_div_opb", div_opb, 32'd0);
    chk("rst_div_func", 32'(div_func), 32'(ALU_DIVU));
    chk("rst_busy_cycles", busy_cycles, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(0, 32'd100, 32'd7, ALU_DIVU, 5'd3, 32'd14, 18, 2'b01, 1'b1);
    chk("busy_cycles_first", busy_cycles, 32'd17);
    run_op(1, 32'hFFFF_FFF9, 32'd2, ALU_REM, 5'd7, 32'hFFFF_FFFF, 18, 2'b10, 1'b1);
    run_op(0, 32'd5, 32'd0, ALU_DIV, 5'd1, 32'hFFFF_FFFF, 2, 2'b01, 1'b1);
    run_op(1, 32'd100, 32'd7, ALU_DIVU, 5'd2, 32'd14, 18, 2'b10, 1'b1);
    run_op(0, 32'd100, 32'd7, ALU_DIVU, 5'd6, 32'd14, 2, 2'b01, 1'b1);
    chk("busy_cycles_sum", busy_cycles, 32'd53);

    // Both requesters hammer the divider; pointer currently favours requester 1.
    @(negedge clk);
    req_valid = 2'b11;
    req_opa[0] = 32'd20; req_opb[0] = 32'd3; req_func[0] = ALU_DIVU; req_tag[0] = 5'd0;
    req_opa[1] = 32'd20; req_opb[1] = 32'd3; req_func[1] = ALU_DIVU; req_tag[1] = 5'd1;
    resp_ready = 2'b11;
    gcount = 0; rc0 = 0; rc1 = 0;
    for (int n = 0; n < 200 && (rc0 + rc1) < 4; n++) begin
      #1;
      if (req_ready != '0 && gcount < 4) begin
        gseq[gcount] = req_ready;
        gcount++;
      end
      if (resp_valid != '0) begin
        chk("fair_data", resp_data, 32'd6);
        chk("fair_tag", 32'(resp_tag), (resp_valid == 2'b10) ? 32'd1 : 32'd0);
        if (resp_valid == 2'b01) rc0++;
        else rc1++;
      end
      @(negedge clk);
      if (gcount >= 4) req_valid = '0;
    end
    resp_ready = '0;
    req_valid = '0;
    chk("fair_g0", 32'(gseq[0]), 32'd2);
    chk("fair_g1", 32'(gseq[1]), 32'd1);
    chk("fair_g2", 32'(gseq[2]), 32'd2);
    chk("fair_g3", 32'(gseq[3]), 32'd1);
    chk("fair_cnt0", 32'(rc0), 32'd2);
    chk("fair_cnt1", 32'(rc1), 32'd2);
    chk("busy_cycles_fair", busy_cycles, 32'd73);

    // Flush the owner mid-RUN: no response may ever appear.
    @(negedge clk);
    req_valid = 2'b01;
    req_opa[0] = 32'd1000; req_opb[0] = 32'd1; req_func[0] = ALU_DIVU; req_tag[0] = 5'd5;
    #1;
    chk("flush_grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    flush[0] = 1'b1;
    @(negedge clk);
    flush = '0;
    seen = 0;
    for (int n = 0; n < 25; n++) begin
      #1;
      if (resp_valid != '0) seen = 1;
      @(negedge clk);
    end
    chk("flush_no_resp", 32'(seen), 32'd0);

    // Flush in IDLE hides the requester from arbitration.
    req_valid = 2'b10;
    req_opa[1] = 32'd1000; req_opb[1] = 32'd7; req_func[1] = ALU_REMU; req_tag[1] = 5'd11;
    flush[1] = 1'b1;
    #1;
    chk("idle_flush_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("idle_flush_hold", 32'(req_ready), 32'd0);
    req_valid = '0;
    flush = '0;
    run_op(1, 32'd1000, 32'd7, ALU_REMU, 5'd11, 32'd6, 18, 2'b10, 1'b1);

    // Response held back: data/tag stable, nobody granted, non-owner flush ignored.
    run_op(0, 32'hFFFF_FFEC, 32'd3, ALU_DIV, 5'd9, 32'hFFFF_FFFA, 18, 2'b01, 1'b0);
    req_valid = 2'b11;
    flush = 2'b10;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      #1;
      chk("hold_data", resp_data, 32'hFFFF_FFFA);
      chk("hold_tag", 32'(resp_tag), 32'd9);
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_valid", 32'(resp_valid), 32'd1);
    end
    @(negedge clk);
    req_valid = '0;
    resp_ready[0] = 1'b1;
    flush = 2'b01;
    @(negedge clk);
    resp_ready = '0;
    flush = '0;
    #1;
    chk("flush_and_ready", 32'(resp_valid), 32'd0);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    req_valid = 2'b10;
    req_opa[1] = 32'd77; req_opb[1] = 32'd5; req_func[1] = ALU_DIVU; req_tag[1] = 5'd4;
    #1;
    chk("rst_op_grant", 32'(req_ready), 32'd2);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_div_opa", div_opa, 32'd0);
    chk("mid_rst_div_opb", div_opb, 32'd0);
    chk("mid_rst_div_func", 32'(div_func), 32'(ALU_DIVU));
    chk("mid_rst_busy_cycles", busy_cycles, 32'd0);
    chk("mid_rst_resp_data", resp_data, 32'd0);
    chk("mid_rst_resp_tag", 32'(resp_tag), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 32'd77, 32'd5, ALU_DIVU, 5'd4, 32'd15, 18, 2'b01, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
